// File: rtl/snake_tilemap_pkg.sv
// Shared constants, state encoding and the nibble-insert helper for the snake tile map.
package snake_tilemap_pkg;

  localparam int unsigned ROWS   = 8;
  localparam int unsigned COLS   = 8;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned ROW_W  = COLS * CODE_W;
  localparam int unsigned ROW_AW = $clog2(ROWS);
  localparam int unsigned COL_AW = $clog2(COLS);

  // Code 0 selects the all-transparent sprite.
  localparam logic [CODE_W-1:0] SPR_EMPTY = '0;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWaitFrame = 2'd1,
    StCopy      = 2'd2,
    StClear     = 2'd3
  } state_e;

  // Replace the code at column col of row_word, keeping every other nibble.
  function automatic logic [ROW_W-1:0] ins_code(input logic [ROW_W-1:0]  row_word,
                                                input logic [COL_AW-1:0] col,
                                                input logic [CODE_W-1:0] code);
    logic [ROW_W-1:0] r;
    r = row_word;
    r[col*CODE_W +: CODE_W] = code;
    return r;
  endfunction

endpackage

// File: rtl/snake_tilemap_bank.sv
// One ROWS x ROW_W tile bank: nibble write port, full-row write port, two async read ports.
module snake_tilemap_bank
  import snake_tilemap_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              nib_we_i,
  input  logic [ROW_AW-1:0] nib_row_i,
  input  logic [COL_AW-1:0] nib_col_i,
  input  logic [CODE_W-1:0] nib_code_i,
  input  logic              row_we_i,
  input  logic [ROW_AW-1:0] row_addr_i,
  input  logic [ROW_W-1:0]  row_data_i,
  input  logic [ROW_AW-1:0] rd0_addr_i,
  output logic [ROW_W-1:0]  rd0_data_o,
  input  logic [ROW_AW-1:0] rd1_addr_i,
  output logic [ROW_W-1:0]  rd1_data_o
);

  logic [ROW_W-1:0] mem_q [ROWS];
  logic [ROW_W-1:0] mem_d [ROWS];

  // Next-state: the two write ports are never active together; row write wins if they were.
  always_comb begin
    mem_d = mem_q;
    if (row_we_i) begin
      mem_d[row_addr_i] = row_data_i;
    end else if (nib_we_i) begin
      mem_d[nib_row_i] = ins_code(mem_q[nib_row_i], nib_col_i, nib_code_i);
    end
  end

  // Storage with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(ROWS); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd0_data_o = mem_q[rd0_addr_i];
  assign rd1_data_o = mem_q[rd1_addr_i];

endmodule

// File: rtl/snake_tilemap.sv
// Double-buffered sprite-code tile map. Game logic writes the back bank; the display reads the
// front bank. Banks swap only on frame_start, then the new front is copied into the back bank.
// Optional macro SNAKE_TILEMAP_CLEAR_EN adds clear_req_i and a CLEAR sweep of the back bank.
module snake_tilemap
  import snake_tilemap_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ROW_AW-1:0] wr_row_i,
  input  logic [COL_AW-1:0] wr_col_i,
  input  logic [CODE_W-1:0] wr_code_i,
  input  logic              swap_req_i,
  output logic              swap_pending_o,
  input  logic              frame_start_i,
  input  logic [5:0]        tile_y_i,
  output logic [ROW_W-1:0]  sprite_addr_o,
`ifdef SNAKE_TILEMAP_CLEAR_EN
  input  logic              clear_req_i,
`endif
  output logic              front_sel_o
);

  state_e            state_q, state_d;
  logic              front_sel_q, front_sel_d;
  logic              pending_q, pending_d;
  logic [ROW_AW-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0]  sprite_q, sprite_d;

  logic              clear_w;
  logic              wr_in_range;
  logic              nib_we;
  logic              row_we;
  logic [ROW_W-1:0]  row_data;
  logic [ROW_W-1:0]  b0_rd0, b0_rd1, b1_rd0, b1_rd1;
  logic [ROW_W-1:0]  front_row, copy_row;

`ifdef SNAKE_TILEMAP_CLEAR_EN
  assign clear_w = clear_req_i;
`else
  assign clear_w = 1'b0;
`endif

  // Out-of-range cells are accepted but dropped.
  assign wr_in_range = (32'(wr_row_i) < ROWS) && (32'(wr_col_i) < COLS);

  assign front_row = front_sel_q ? b1_rd0 : b0_rd0;
  assign copy_row  = front_sel_q ? b1_rd1 : b0_rd1;

  // Next-state and write-port control; writes always target the back bank (~front_sel_q).
  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    nib_we      = 1'b0;
    row_we      = 1'b0;
    row_data    = copy_row;
    wr_ready_o  = (state_q == StIdle) && !clear_w;

    unique case (state_q)
      StIdle: begin
        // The write lands in the current back bank, which a same-edge swap then publishes.
        nib_we = wr_valid_i && wr_ready_o && wr_in_range;
        if (swap_req_i && frame_start_i) begin
          front_sel_d = ~front_sel_q;
          cnt_d       = '0;
          state_d     = StCopy;
        end else if (swap_req_i) begin
          pending_d = 1'b1;
          state_d   = StWaitFrame;
        end else if (clear_w) begin
          cnt_d   = '0;
          state_d = StClear;
        end
      end
      StWaitFrame: begin
        if (frame_start_i) begin
          front_sel_d = ~front_sel_q;
          pending_d   = 1'b0;
          cnt_d       = '0;
          state_d     = StCopy;
        end
      end
`ifdef SNAKE_TILEMAP_CLEAR_EN
      StCopy, StClear: begin
`else
      StCopy: begin
`endif
        row_we = 1'b1;
        if (state_q == StClear) begin
          row_data = '0;
        end
        if (swap_req_i) begin
          pending_d = 1'b1;
        end
        if (cnt_q == ROW_AW'(ROWS - 1)) begin
          cnt_d   = '0;
          state_d = (pending_q || swap_req_i) ? StWaitFrame : StIdle;
        end else begin
          cnt_d = cnt_q + ROW_AW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    sprite_d = (tile_y_i < 6'(ROWS)) ? front_row : '0;
  end

  // Control and read-path registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      front_sel_q <= 1'b0;
      pending_q   <= 1'b0;
      cnt_q       <= '0;
      sprite_q    <= '0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      sprite_q    <= sprite_d;
    end
  end

  snake_tilemap_bank u_bank0 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .nib_we_i   (nib_we && front_sel_q),
    .nib_row_i  (wr_row_i),
    .nib_col_i  (wr_col_i),
    .nib_code_i (wr_code_i),
    .row_we_i   (row_we && front_sel_q),
    .row_addr_i (cnt_q),
    .row_data_i (row_data),
    .rd0_addr_i (tile_y_i[ROW_AW-1:0]),
    .rd0_data_o (b0_rd0),
    .rd1_addr_i (cnt_q),
    .rd1_data_o (b0_rd1)
  );

  snake_tilemap_bank u_bank1 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .nib_we_i   (nib_we && !front_sel_q),
    .nib_row_i  (wr_row_i),
    .nib_col_i  (wr_col_i),
    .nib_code_i (wr_code_i),
    .row_we_i   (row_we && !front_sel_q),
    .row_addr_i (cnt_q),
    .row_data_i (row_data),
    .rd0_addr_i (tile_y_i[ROW_AW-1:0]),
    .rd0_data_o (b1_rd0),
    .rd1_addr_i (cnt_q),
    .rd1_data_o (b1_rd1)
  );

  assign sprite_addr_o  = sprite_q;
  assign swap_pending_o = pending_q;
  assign front_sel_o    = front_sel_q;

endmodule

// File: tb/tb_snake_tilemap.sv
// Self-checking bench for snake_tilemap: directed scenarios plus randomized traffic, all checked
// against a board-level model (two code arrays, a pending flag and a busy countdown).
module tb_snake_tilemap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [2:0]  wr_row = '0;
  logic [2:0]  wr_col = '0;
  logic [3:0]  wr_code = '0;
  logic        swap_req = 1'b0;
  logic        frame_start = 1'b0;
  logic        clear_req = 1'b0;
  logic [5:0]  tile_y = '0;
  logic        wr_ready;
  logic        swap_pending;
  logic        front_sel;
  logic [31:0] sprite_addr;

  always #5 clk = ~clk;

  snake_tilemap dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready),
    .wr_row_i       (wr_row),
    .wr_col_i       (wr_col),
    .wr_code_i      (wr_code),
    .swap_req_i     (swap_req),
    .swap_pending_o (swap_pending),
    .frame_start_i  (frame_start),
    .tile_y_i       (tile_y),
    .sprite_addr_o  (sprite_addr),
`ifdef SNAKE_TILEMAP_CLEAR_EN
    .clear_req_i    (clear_req),
`endif
    .front_sel_o    (front_sel)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Board model: m_bank[b][row][col] holds a code; m_fsel picks the displayed bank.
  // A swap flips m_fsel and copies the whole front board into the back at once; the
  // hardware sweep is represented only by m_busy cycles during which writes are refused.
  logic [3:0] m_bank [2][8][8];
  bit         m_fsel;
  bit         m_pend;
  int         m_busy;

  function automatic logic [31:0] m_row(input bit b, input int r);
    logic [31:0] w;
    w = '0;
    for (int c = 0; c < 8; c++) w[4*c +: 4] = m_bank[b][r][c];
    return w;
  endfunction

  task automatic m_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) m_bank[b][r][c] = 4'h0;
    m_fsel = 1'b0;
    m_pend = 1'b0;
    m_busy = 0;
  endtask

  task automatic m_publish();
    m_fsel = !m_fsel;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) m_bank[!m_fsel][r][c] = m_bank[m_fsel][r][c];
    m_busy = 8;
  endtask

  // Advance one clock: update the model from the current inputs, then compare all outputs.
  task automatic step();
    logic [31:0] exp_spr;
    bit          idle;
    exp_spr = (tile_y < 6'd8) ? m_row(m_fsel, int'(tile_y)) : 32'h0;
    if (rst) begin
      m_reset();
      exp_spr = 32'h0;
    end else begin
      idle = (m_busy == 0) && !m_pend;
      if (idle) begin
        if (wr_valid && !clear_req) m_bank[!m_fsel][wr_row][wr_col] = wr_code;
        if (swap_req && frame_start) begin
          m_publish();
        end else if (swap_req) begin
          m_pend = 1'b1;
        end else if (clear_req) begin
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) m_bank[!m_fsel][r][c] = 4'h0;
          m_busy = 8;
        end
      end else if (m_busy > 0) begin
        if (swap_req) m_pend = 1'b1;
        m_busy--;
      end else if (frame_start) begin
        m_pend = 1'b0;
        m_publish();
      end
    end
    @(posedge clk);
    #1;
    check("sprite_addr", sprite_addr, exp_spr);
    check("front_sel", {31'b0, front_sel}, {31'b0, m_fsel});
    check("swap_pending", {31'b0, swap_pending}, {31'b0, m_pend});
    check("wr_ready", {31'b0, wr_ready},
          {31'b0, (m_busy == 0) && !m_pend && !clear_req});
  endtask

  task automatic quiet();
    wr_valid    = 1'b0;
    swap_req    = 1'b0;
    frame_start = 1'b0;
    clear_req   = 1'b0;
  endtask

  task automatic idle_wait();
    int n;
    quiet();
    n = 0;
    while (!wr_ready && n < 40) begin
      step();
      n++;
    end
    check("idle_reached", {31'b0, wr_ready}, 32'd1);
  endtask

  int lows;

  initial begin
    m_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state: every row empty, bank 0 displayed, writes accepted.
    for (int y = 0; y < 8; y++) begin
      tile_y = 6'(y);
      step();
      check("t1_row", sprite_addr, 32'h0);
    end
    check("t1_fsel", {31'b0, front_sel}, 32'd0);
    check("t1_ready", {31'b0, wr_ready}, 32'd1);

    // Write + swap request, frame_start ten clocks later.
    wr_valid = 1'b1; wr_row = 3'd2; wr_col = 3'd3; wr_code = 4'hA; swap_req = 1'b1;
    step();
    quiet();
    check("t2_pend0", {31'b0, swap_pending}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      step();
      check("t2_pend", {31'b0, swap_pending}, 32'd1);
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("t2_fsel", {31'b0, front_sel}, 32'd1);
    lows = wr_ready ? 0 : 1;
    tile_y = 6'd2;
    step();
    check("t2_row2", sprite_addr, 32'h0000_A000);
    if (!wr_ready) lows++;
    for (int n = 0; n < 30 && !wr_ready; n++) begin
      step();
      if (!wr_ready) lows++;
    end
    check("t3_ready_low", 32'(lows), 32'd8);

    // Incremental write on top of the copied board.
    wr_valid = 1'b1; wr_row = 3'd2; wr_col = 3'd0; wr_code = 4'h5;
    swap_req = 1'b1; frame_start = 1'b1;
    step();
    quiet();
    step();
    check("t3_row2", sprite_addr, 32'h0000_A005);
    idle_wait();

    // Write, swap request and frame_start in one cycle.
    wr_valid = 1'b1; wr_row = 3'd7; wr_col = 3'd7; wr_code = 4'hF;
    swap_req = 1'b1; frame_start = 1'b1;
    step();
    quiet();
    tile_y = 6'd7;
    step();
    check("t4_row7", sprite_addr, 32'hF000_0000);
    idle_wait();

    // swap_req and frame_start during COPY.
    swap_req = 1'b1; frame_start = 1'b1;
    step();
    quiet();
    lows = int'(front_sel);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("t5_no_swap", {31'b0, front_sel}, 32'(lows));
    for (int i = 0; i < 6; i++) step();
    check("t5_pend", {31'b0, swap_pending}, 32'd1);
    check("t5_ready", {31'b0, wr_ready}, 32'd0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("t5_swapped", {31'b0, front_sel}, 32'(lows ^ 1));
    idle_wait();

`ifdef SNAKE_TILEMAP_CLEAR_EN
    // Fill the back bank, clear it, publish it.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        wr_valid = 1'b1; wr_row = 3'(r); wr_col = 3'(c); wr_code = 4'h3;
        step();
      end
    wr_valid = 1'b0;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    lows = wr_ready ? 0 : 1;
    for (int n = 0; n < 30 && !wr_ready; n++) begin
      step();
      if (!wr_ready) lows++;
    end
    check("t6_ready_low", 32'(lows), 32'd8);
    swap_req = 1'b1; frame_start = 1'b1;
    step();
    quiet();
    for (int y = 0; y < 8; y++) begin
      tile_y = 6'(y);
      step();
      check("t6_row", sprite_addr, 32'h0);
    end
    idle_wait();
    // Reset in the middle of a CLEAR with a swap pending.
    wr_valid = 1'b1; wr_row = 3'd1; wr_col = 3'd1; wr_code = 4'h9;
    swap_req = 1'b1; frame_start = 1'b1;
    step();
    quiet();
    idle_wait();
    tile_y = 6'd1;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_spr", sprite_addr, 32'h0);
    check("t6_rst_fsel", {31'b0, front_sel}, 32'd0);
    check("t6_rst_pend", {31'b0, swap_pending}, 32'd0);
    check("t6_rst_ready", {31'b0, wr_ready}, 32'd1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      wr_valid    = 1'($urandom_range(0, 1));
      wr_row      = 3'($urandom_range(0, 7));
      wr_col      = 3'($urandom_range(0, 7));
      wr_code     = 4'($urandom_range(0, 15));
      swap_req    = ($urandom_range(0, 15) == 0);
      frame_start = ($urandom_range(0, 11) == 0);
      tile_y      = 6'($urandom_range(0, 11));
`ifdef SNAKE_TILEMAP_CLEAR_EN
      clear_req   = ($urandom_range(0, 19) == 0);
`endif
      rst         = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    quiet();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
